muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 118 +++++++++++
 tb/tb_muldiv_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: shared multi-cycle signed MUL/DIV/MOD engine with pipeline stall
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isMul,
  input  logic             isDiv,
  input  logic             isMod,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int ITER = WIDTH;
  localparam logic [1:0] OP_MUL = 2'd0, OP_DIV = 2'd1, OP_MOD = 2'd2;
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d, fix_val;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic op_valid, accept, div_zero, ge;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0] rem_sh, rem_nx;
  assign op_valid = isMul | isDiv | isMod;
  assign accept   = (state_q == IDLE) & start & op_valid & ~flush;
  assign div_zero = (op_q != OP_MUL) & (b_q == '0);
  assign abs_a    = a_q[WIDTH-1] ? -a_q : a_q;
  assign abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, b_q};
  assign rem_nx   = ge ? rem_sh - {1'b0, b_q} : rem_sh;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? PREP : IDLE;
      PREP:    state_d = div_zero ? FIX : RUN;
      RUN:     state_d = (cnt_q == CW'(ITER-1)) ? FIX : RUN;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) state_d = IDLE;
  end
  // Quotient bits shift into a_q as dividend bits shift out; acc_q is the remainder.
  always_comb begin
    fix_val = op_q == OP_MUL ? ((sa_q ^ sb_q) ? -acc_q : acc_q) :
              op_q == OP_DIV ? (b_q == '0 ? {WIDTH{1'b1}} : (sa_q ^ sb_q) ? -a_q : a_q) :
              (sa_q ? -acc_q : acc_q);
  end
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (accept) begin
        a_d  = op_a;
        b_d  = op_b;
        op_d = isMul ? OP_MUL : isDiv ? OP_DIV : OP_MOD;
      end
      PREP: begin
        sa_d  = a_q[WIDTH-1];
        sb_d  = b_q[WIDTH-1];
        a_d   = abs_a;
        b_d   = abs_b;
        acc_d = div_zero ? abs_a : '0;
        cnt_d = '0;
      end
      RUN: begin
        acc_d = op_q == OP_MUL ? acc_q + (b_q[0] ? a_q : '0) : rem_nx[WIDTH-1:0];
        a_d   = op_q == OP_MUL ? a_q << 1 : {a_q[WIDTH-2:0], ge};
        b_d   = op_q == OP_MUL ? b_q >> 1 : b_q;
        cnt_d = cnt_q + 1'b1;
      end
      FIX: result_d = flush ? result_q : fix_val;
      default: ;
    endcase
  end
  always_comb begin
    busy   = (state_q == PREP) | (state_q == RUN) | (state_q == FIX);
    done   = state_q == DONE;
    stall  = ((state_q == IDLE) & start & op_valid) | busy;
    result = result_q;
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 0, rst = 0, start = 0, is_mul = 0, is_div = 0, is_mod = 0, flush = 0;
  logic [31:0] op_a = 0, op_b = 0, result;
  logic busy, stall, done;
  int n_cmp = 0, n_err = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .isMul(is_mul), .isDiv(is_div), .isMod(is_mod),
    .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic run_op(input string nm, input logic [2:0] fl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_cyc,
                        input bit hold);
    int cyc;
    bit st_ok;
    @(negedge clk);
    start = 1; {is_mul, is_div, is_mod} = fl; op_a = a; op_b = b;
    #1;
    st_ok = (stall === 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) begin start = 0; {is_mul, is_div, is_mod} = 3'b000; end
      #1;
      if (done !== 1'b1 && stall !== 1'b1) st_ok = 0;
    end
    n_cmp++; if (!st_ok) begin n_err++; $display("FAIL %s stall: dropped before done, required high", nm); end
    n_cmp++; if (cyc != exp_cyc) begin n_err++; $display("FAIL %s latency: got %0d required %0d", nm, cyc, exp_cyc); end
    n_cmp++; if (result !== exp_r) begin n_err++; $display("FAIL %s result: got %h required %h", nm, result, exp_r); end
    n_cmp++; if (stall !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s done_cycle: stall=%b busy=%b required 0 0", nm, stall, busy); end
    start = 0; {is_mul, is_div, is_mod} = 3'b000;
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s after_done: done=%b busy=%b required 0 0", nm, done, busy); end
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy, stall, done, result} !== 35'd0) begin n_err++; $display("FAIL reset: busy=%b stall=%b done=%b result=%h required all 0", busy, stall, done, result); end
    rst = 1;
  endtask

  task automatic test_no_flag;
    @(negedge clk); start = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL noflag_stall: got %b required 0", stall); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL noflag_busy: got %b required 0", busy); end
    start = 0;
  endtask

  task automatic test_mul;
    run_op("mul_7x-3", 3'b100, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 35, 0);
    run_op("mul_-6x-9", 3'b100, 32'hFFFFFFFA, 32'hFFFFFFF7, 32'd54, 35, 0);
  endtask

  task automatic test_div_mod;
    run_op("div_-7/2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, 0);
    run_op("mod_-7%2", 3'b001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, 0);
    run_op("mod_7%-2", 3'b001, 32'd7, 32'hFFFFFFFE, 32'd1, 35, 0);
    run_op("div_100/7", 3'b010, 32'd100, 32'd7, 32'd14, 35, 0);
    run_op("mod_100%-7", 3'b001, 32'd100, 32'hFFFFFFF9, 32'd2, 35, 0);
  endtask

  task automatic test_div_zero;
    run_op("div_5/0", 3'b010, 32'd5, 32'd0, 32'hFFFFFFFF, 3, 0);
    run_op("mod_5%0", 3'b001, 32'd5, 32'd0, 32'd5, 3, 0);
    run_op("mod_-5%0", 3'b001, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 3, 0);
  endtask

  task automatic test_overflow;
    run_op("div_min/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 0);
    run_op("mod_min%-1", 3'b001, 32'h80000000, 32'hFFFFFFFF, 32'd0, 35, 0);
    run_op("mul_minx-1", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 0);
  endtask

  task automatic test_flush;
    bit saw_done;
    @(negedge clk); start = 1; is_div = 1; op_a = 100; op_b = 7; flush = 1;
    @(posedge clk); #1;
    start = 0; is_div = 0; flush = 0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_start: busy=%b required 0", busy); end
    @(negedge clk); start = 1; is_div = 1;
    @(posedge clk); #1;
    start = 0; is_div = 0;
    repeat (9) @(posedge clk);
    #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL flush_busy: busy=%b done=%b required 0 0", busy, done); end
    saw_done = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1; end
    n_cmp++; if (saw_done) begin n_err++; $display("FAIL flush_nodone: done pulse seen, required none"); end
    n_cmp++; if (result !== 32'h80000000) begin n_err++; $display("FAIL flush_result: got %h required 80000000", result); end
    run_op("div_after_flush", 3'b010, 32'd100, 32'd7, 32'd14, 35, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk); start = 1; is_mul = 1; op_a = 3; op_b = 5;
    @(posedge clk); #1;
    start = 0; is_mul = 0;
    repeat (19) @(posedge clk);
    #1; rst = 0;
    @(posedge clk); #1;
    n_cmp++; if ({busy, stall, done, result} !== 35'd0) begin n_err++; $display("FAIL reset_mid: busy=%b stall=%b done=%b result=%h required all 0", busy, stall, done, result); end
    rst = 1;
  endtask

  task automatic test_back_to_back;
    run_op("all_flags_mul", 3'b111, 32'd6, 32'd7, 32'd42, 35, 0);
    run_op("hold_start", 3'b100, 32'd3, 32'd4, 32'd12, 35, 1);
    run_op("b2b_div", 3'b010, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 35, 0);
  endtask

  initial begin
    test_reset();
    test_no_flag();
    test_mul();
    test_div_mod();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
